// File: rtl/myfilter_pkg.sv
// Shared types and constants for the I2C slave receive path.
//   i2c_rx_state_t : receive FSM state encoding
//   I2C_BYTE_BITS  : data bits per I2C byte (acknowledge clock excluded)
package myfilter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    ACK_WAIT = 2'd2,
    ACK      = 2'd3
  } i2c_rx_state_t;

  localparam int I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Bus-line synchronizer: SYNC_STAGES flops followed by one delay flop, so the
// parent can see both the current and the previous synchronized sample.
// Every flop resets to 1, which is the idle level of an I2C line.
//   clk, rst_n : system clock, synchronous active-low reset
//   d_in       : raw pad input, asynchronous to clk
//   s_out      : synchronized sample
//   d_out      : s_out delayed by one clock
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic s_out,
  output logic d_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_out = sync_q[SYNC_STAGES-1];
  assign d_out = dly_q;

endmodule

// File: rtl/i2c_rx_byte.sv
// I2C slave receive front end. Synchronizes SCL/SDA, detects START, repeated
// START and STOP, shifts bytes in MSB-first on SCL rising edges and marks the
// 9th (acknowledge) clock for the SDA output mux.
//   clk, rst_n   : system clock, synchronous active-low reset
//   scl_in       : raw SCL pad input
//   sda_in       : raw SDA pad input
//   start_out    : one-clock pulse on START / repeated START
//   stop_out     : one-clock pulse on STOP
//   rdata_out    : last complete byte, held until the next one completes
//   rvalid_out   : one-clock pulse when rdata_out updates
//   ack_slot_out : high for the whole 9th SCL clock
//   busy_out     : high between START and STOP
// The FSM state is held in state_q for observation.
module i2c_rx_byte
  import myfilter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       start_out,
  output logic       stop_out,
  output logic [7:0] rdata_out,
  output logic       rvalid_out,
  output logic       ack_slot_out,
  output logic       busy_out
);

  localparam int CNT_W = $clog2(I2C_BYTE_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(I2C_BYTE_BITS - 1);

  logic scl_s, scl_d, sda_s, sda_d;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (scl_in),
    .s_out(scl_s),
    .d_out(scl_d)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (sda_in),
    .s_out(sda_s),
    .d_out(sda_d)
  );

  // START/STOP need SCL high in both samples, so an SDA change that lands in
  // the same sample as an SCL edge never qualifies as a bus condition.
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

  // Events are registered before the FSM; the SDA sample travels with them so
  // the bit shifted in is the one seen at the SCL rising edge.
  logic rise_ev_q, fall_ev_q, start_ev_q, stop_ev_q, sda_bit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_ev_q  <= 1'b0;
      fall_ev_q  <= 1'b0;
      start_ev_q <= 1'b0;
      stop_ev_q  <= 1'b0;
      sda_bit_q  <= 1'b0;
    end else begin
      rise_ev_q  <= scl_rise;
      fall_ev_q  <= scl_fall;
      start_ev_q <= start_det;
      stop_ev_q  <= stop_det;
      sda_bit_q  <= sda_s;
    end
  end

  i2c_rx_state_t              state_q, state_n;
  logic [CNT_W-1:0]           cnt_q, cnt_n;
  logic [I2C_BYTE_BITS-1:0]   shift_q, shift_n;
  logic [I2C_BYTE_BITS-1:0]   rdata_q, rdata_n;
  logic                       start_q, start_n;
  logic                       stop_q, stop_n;
  logic                       rvalid_q, rvalid_n;
  logic                       ack_q, busy_q;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    shift_n  = shift_q;
    rdata_n  = rdata_q;
    start_n  = 1'b0;
    stop_n   = 1'b0;
    rvalid_n = 1'b0;
    if (start_ev_q) begin
      // START or repeated START: drop any partial byte and restart framing.
      start_n = 1'b1;
      state_n = DATA;
      cnt_n   = '0;
      shift_n = '0;
    end else if (stop_ev_q) begin
      // Partial byte is abandoned; rdata_q deliberately keeps the last byte.
      stop_n  = 1'b1;
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = IDLE;
        end
        DATA: begin
          if (rise_ev_q) begin
            shift_n = {shift_q[I2C_BYTE_BITS-2:0], sda_bit_q};
            cnt_n   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              rdata_n  = {shift_q[I2C_BYTE_BITS-2:0], sda_bit_q};
              rvalid_n = 1'b1;
              state_n  = ACK_WAIT;
            end
          end
        end
        ACK_WAIT: begin
          if (fall_ev_q) state_n = ACK;
        end
        ACK: begin
          if (fall_ev_q) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // busy/ack are registered from the next state so they change on the same
  // clock as the state itself and as the start/stop pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      shift_q  <= shift_n;
      rdata_q  <= rdata_n;
      start_q  <= start_n;
      stop_q   <= stop_n;
      rvalid_q <= rvalid_n;
      ack_q    <= (state_n == ACK);
      busy_q   <= (state_n != IDLE);
    end
  end

  assign start_out    = start_q;
  assign stop_out     = stop_q;
  assign rdata_out    = rdata_q;
  assign rvalid_out   = rvalid_q;
  assign ack_slot_out = ack_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_i2c_rx_byte.sv
// Bench for i2c_rx_byte. Two instances share the bus pins: index 0 uses the
// default synchronizer depth, index 1 uses SYNC_STAGES=3. A bit-level model of
// the I2C framing predicts bytes, pulses and acknowledge windows.
module tb_i2c_rx_byte;

  localparam int HP = 8;  // SCL half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, scl, sda;
  logic       start_o[2], stop_o[2], rvalid_o[2], ack_o[2], busy_o[2];
  logic [7:0] rdata_o[2];

  i2c_rx_byte #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda),
    .start_out(start_o[0]), .stop_out(stop_o[0]), .rdata_out(rdata_o[0]),
    .rvalid_out(rvalid_o[0]), .ack_slot_out(ack_o[0]), .busy_out(busy_o[0])
  );

  i2c_rx_byte #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda),
    .start_out(start_o[1]), .stop_out(stop_o[1]), .rdata_out(rdata_o[1]),
    .rvalid_out(rvalid_o[1]), .ack_slot_out(ack_o[1]), .busy_out(busy_o[1])
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         ack_lens[$];
  int         ack_len = 0;
  int         n_start2 = 0, n_stop2 = 0, n_start3 = 0, n_stop3 = 0, n_rv3 = 0;

  always @(negedge clk) begin
    if (rvalid_o[0] === 1'b1) obs_q.push_back(rdata_o[0]);
    if (start_o[0] === 1'b1) begin
      n_start2++;
      check("busy_at_start", 32'(busy_o[0]), 32'd1);
    end
    if (stop_o[0] === 1'b1) begin
      n_stop2++;
      check("busy_at_stop", 32'(busy_o[0]), 32'd0);
    end
    if (ack_o[0] === 1'b1) ack_len++;
    else if (ack_len != 0) begin
      ack_lens.push_back(ack_len);
      ack_len = 0;
    end
    if (rvalid_o[1] === 1'b1) n_rv3++;
    if (start_o[1] === 1'b1) n_start3++;
    if (stop_o[1] === 1'b1) n_stop3++;
  end

  // ---------------- reference model (bus-symbol level) ----------------
  int         exp_starts = 0, exp_stops = 0, exp_acks = 0;
  logic       m_in_frame = 1'b0, m_ack_phase = 1'b0;
  int         m_nbits = 0;
  logic [7:0] m_acc = 8'h00, m_rdata = 8'h00;

  function automatic void model_start();
    exp_starts++;
    m_in_frame  = 1'b1;
    m_ack_phase = 1'b0;
    m_nbits     = 0;
    m_acc       = 8'h00;
  endfunction

  function automatic void model_stop();
    exp_stops++;
    m_in_frame = 1'b0;
  endfunction

  // One complete SCL clock carrying bit b.
  function automatic void model_clock(input logic b);
    if (!m_in_frame) return;
    if (m_ack_phase) begin
      exp_acks++;
      m_ack_phase = 1'b0;
      m_nbits     = 0;
      m_acc       = 8'h00;
    end else begin
      m_acc = 8'((m_acc * 2 + b) % 256);
      m_nbits++;
      if (m_nbits == 8) begin
        exp_q.push_back(m_acc);
        m_rdata     = m_acc;
        m_ack_phase = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    wait_clks(HP / 2);
    sda = 1'b1;
    wait_clks(HP);
    scl = 1'b1;
    wait_clks(HP);
    sda = 1'b0;
    wait_clks(HP);
    scl = 1'b0;
    model_start();
  endtask

  task automatic bus_stop();
    wait_clks(HP / 2);
    sda = 1'b0;
    wait_clks(HP);
    scl = 1'b1;
    wait_clks(HP);
    sda = 1'b1;
    wait_clks(HP);
    model_stop();
  endtask

  task automatic bus_bit(input logic b);
    wait_clks(HP / 2);
    sda = b;
    wait_clks(HP / 2);
    scl = 1'b1;
    wait_clks(HP);
    scl = 1'b0;
    model_clock(b);
  endtask

  // SDA changes in the very same sample as both SCL edges.
  task automatic bus_bit_sim(input logic b);
    wait_clks(HP);
    sda = b;
    scl = 1'b1;
    wait_clks(HP);
    scl = 1'b0;
    sda = ~b;
    model_clock(b);
  endtask

  // nbits data bits MSB-first; a full byte is followed by its ack clock.
  task automatic bus_byte(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) bus_bit(d[7-i]);
    if (nbits == 8) bus_bit(1'b0);
  endtask

  task automatic check_scenario(input string name);
    wait_clks(3 * HP);
    check({name, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({name, "_starts"}, 32'(n_start2), 32'(exp_starts));
    check({name, "_stops"}, 32'(n_stop2), 32'(exp_stops));
    check({name, "_ack_windows"}, 32'(ack_lens.size()), 32'(exp_acks));
    foreach (ack_lens[i]) check({name, "_ack_len"}, 32'(ack_lens[i]), 32'(2 * HP));
    check({name, "_rdata"}, 32'(rdata_o[0]), 32'(m_rdata));
    check({name, "_busy"}, 32'(busy_o[0]), 32'(m_in_frame));
    check({name, "_s3_starts"}, 32'(n_start3), 32'(exp_starts));
    check({name, "_s3_stops"}, 32'(n_stop3), 32'(exp_stops));
    check({name, "_s3_nbytes"}, 32'(n_rv3), 32'(exp_q.size()));
    check({name, "_s3_rdata"}, 32'(rdata_o[1]), 32'(m_rdata));
    exp_q.delete();
    obs_q.delete();
    ack_lens.delete();
    n_start2 = 0; n_stop2 = 0; n_start3 = 0; n_stop3 = 0; n_rv3 = 0;
    exp_starts = 0; exp_stops = 0; exp_acks = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic [7:0] exp_rdata;
    int         exp_rv;
    int         exp_acks;
  } vec_t;

  vec_t vecs[6];

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // ---------------- main test ----------------
  initial begin
    int         lat2, lat3, nb, pb;
    logic [7:0] rb;

    vecs[0] = '{8'hA5, 8, 8'hA5, 1, 1};
    vecs[1] = '{8'hE0, 3, 8'hA5, 0, 0};
    vecs[2] = '{8'h00, 8, 8'h00, 1, 1};
    vecs[3] = '{8'hFF, 8, 8'hFF, 1, 1};
    vecs[4] = '{8'h12, 6, 8'hFF, 0, 0};
    vecs[5] = '{8'h81, 8, 8'h81, 1, 1};

    // Reset with both lines low, release onto an idle bus.
    rst_n = 1'b0;
    scl   = 1'b0;
    sda   = 1'b0;
    wait_clks(5);
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    check("reset_rdata", 32'(rdata_o[0]), 32'd0);
    scl   = 1'b1;
    sda   = 1'b1;
    rst_n = 1'b1;
    wait_clks(10);
    check("post_reset_starts", 32'(n_start2 + n_start3), 32'd0);
    check("post_reset_stops", 32'(n_stop2 + n_stop3), 32'd0);
    check("post_reset_rvalid", 32'(obs_q.size()), 32'd0);
    check("post_reset_outs", 32'({start_o[0], stop_o[0], rvalid_o[0], ack_o[0], busy_o[0]}), 32'd0);
    check("post_reset_rdata", 32'(rdata_o[0]), 32'd0);
    check("post_reset_s3_busy", 32'(busy_o[1]), 32'd0);

    // Table: START, nbits data (+ack if full), STOP.
    for (int v = 0; v < 6; v++) begin
      bus_start();
      bus_byte(vecs[v].data, vecs[v].nbits);
      bus_stop();
      wait_clks(3 * HP);
      check("tbl_rvalid_count", 32'(obs_q.size()), 32'(vecs[v].exp_rv));
      check("tbl_rdata", 32'(rdata_o[0]), 32'(vecs[v].exp_rdata));
      check("tbl_ack_windows", 32'(ack_lens.size()), 32'(vecs[v].exp_acks));
      check("tbl_starts", 32'(n_start2), 32'd1);
      check("tbl_stops", 32'(n_stop2), 32'd1);
      check_scenario("tbl");
    end

    // Back-to-back bytes without STOP.
    bus_start();
    bus_byte(8'h3C, 8);
    bus_byte(8'hFF, 8);
    bus_stop();
    check_scenario("b2b");

    // Repeated START after 5 bits, then a full byte.
    bus_start();
    bus_byte(8'hB0, 5);
    bus_start();
    bus_byte(8'h81, 8);
    bus_stop();
    check_scenario("rstart");

    // SDA toggling in the same sample as SCL edges.
    bus_start();
    for (int i = 0; i < 8; i++) begin
      rb = 8'h5A;
      bus_bit_sim(rb[7-i]);
    end
    bus_bit(1'b0);
    bus_stop();
    check_scenario("simul");

    // START and STOP latency for both synchronizer depths.
    wait_clks(2);
    sda = 1'b0;
    model_start();
    lat2 = -1;
    lat3 = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (start_o[0] === 1'b1 && lat2 < 0) lat2 = k;
      if (start_o[1] === 1'b1 && lat3 < 0) lat3 = k;
    end
    check("start_latency_s2", 32'(lat2), 32'd4);
    check("start_latency_s3", 32'(lat3), 32'd5);
    wait_clks(HP);
    scl = 1'b0;
    bus_byte(8'h96, 8);
    wait_clks(HP / 2);
    sda = 1'b0;
    wait_clks(HP);
    scl = 1'b1;
    wait_clks(HP);
    sda = 1'b1;
    model_stop();
    lat2 = -1;
    lat3 = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (stop_o[0] === 1'b1 && lat2 < 0) lat2 = k;
      if (stop_o[1] === 1'b1 && lat3 < 0) lat3 = k;
    end
    check("stop_latency_s2", 32'(lat2), 32'd4);
    check("stop_latency_s3", 32'(lat3), 32'd5);
    check_scenario("latency");

    // Randomized frames against the model.
    for (int t = 0; t < 12; t++) begin
      bus_start();
      nb = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        rb = 8'($urandom_range(0, 255));
        bus_byte(rb, 8);
      end
      pb = int'($urandom_range(0, 6));
      rb = 8'($urandom_range(0, 255));
      bus_byte(rb, pb);
      if ($urandom_range(0, 1) == 1) begin
        bus_start();
        rb = 8'($urandom_range(0, 255));
        bus_byte(rb, 8);
      end
      bus_stop();
      check_scenario("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_rx_byte.md
# i2c_rx_byte

Receive-side front end of the I2C slave. Synchronizes the raw SCL/SDA bus inputs and detects START, repeated START and STOP. Shifts in one byte MSB-first on SCL rising edges and flags the 9th-clock acknowledge slot. It feeds the byte handler upstream, and its `ack_slot_out` drives the output-select/enable logic of the SDA output mux.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops per bus line; legal values ≥ 2.

Ports:
- `clk`, in, 1: system clock; sole clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `scl_in`, in, 1: raw SCL from pad; asynchronous to `clk`.
- `sda_in`, in, 1: raw SDA from pad; asynchronous to `clk`.
- `start_out`, out, 1: one-cycle pulse on START or repeated START.
- `stop_out`, out, 1: one-cycle pulse on STOP.
- `rdata_out`, out, 8: last complete received byte; held until the next byte completes.
- `rvalid_out`, out, 1: one-cycle pulse when `rdata_out` updates.
- `ack_slot_out`, out, 1: high for the whole 9th SCL clock (from SCL fall after bit 8 until the next SCL fall).
- `busy_out`, out, 1: high from START until STOP.

## Operation
- Sync chain per line: `SYNC_STAGES` flops reset to 1 (idle bus), followed by one delay flop. `scl_s`/`sda_s` are the sync outputs; `scl_d`/`sda_d` are the delayed copies.
- Events, evaluated every cycle:
  - `scl_rise` = `scl_s & ~scl_d`
  - `scl_fall` = `~scl_s & scl_d`
  - START = `scl_s & scl_d & sda_d & ~sda_s`
  - STOP = `scl_s & scl_d & ~sda_d & sda_s`
- If SCL and SDA change in the same sample, no START or STOP is detected; the SCL edge is processed normally.
- FSM states are IDLE, DATA, ACK_WAIT and ACK. Transitions:
  - **IDLE:** START → DATA, bit count cleared. All SCL edges are ignored.
  - **DATA:** on `scl_rise`, shift `sda_s` into the shift register LSB and increment the 3-bit count. On the 8th rise, load `rdata_out` from {shift[6:0], `sda_s`}, pulse `rvalid_out`, and go to ACK_WAIT.
  - **ACK_WAIT:** `scl_fall` → ACK.
  - **ACK:** `ack_slot_out` = 1. `scl_fall` → DATA with count 0; the next byte follows immediately.
- START in any state → pulse `start_out`, go to DATA, clear count and shift register. A repeated START never pulses `rvalid_out`.
- STOP in any state → pulse `stop_out`, go to IDLE. A partial byte is discarded and `rdata_out` is unchanged.
- START/STOP take priority over SCL edges; they cannot coincide with an SCL edge by construction.
- `busy_out` = (state != IDLE).

## Timing
- Reset (`rst_n` low at a `clk` edge):
  - state = IDLE
  - sync and delay flops = 1
  - shift register, count and `rdata_out` = 0
  - `start_out`, `stop_out`, `rvalid_out`, `ack_slot_out` and `busy_out` = 0
- Reset mid-byte abandons the byte. No pulse is emitted when reset releases.
- All outputs are registered.
- Latency from a raw pin transition to an event pulse or state change: `SYNC_STAGES`+2 clocks (4 at default).
- Pulse width: exactly one clock.
- Minimum SCL high/low time for correct sampling: `SYNC_STAGES`+2 clocks.

## Structure
- `myfilter_pkg` holds:
  - `i2c_rx_state_t`: enum IDLE, DATA, ACK_WAIT, ACK.
  - `I2C_BYTE_BITS` = 8.
- Sub-module `i2c_sync_edge`, instantiated once each for SCL and SDA:
  - Parameter: `SYNC_STAGES`.
  - Ports: `clk`, `rst_n`, `d_in`, `s_out`, `d_out`.
  - Holds the sync chain plus the delay flop.

## Test plan
- **Reset:** hold `rst_n`=0 with `scl_in`=`sda_in`=0, then release with both lines = 1. All outputs must be 0, with no `start_out` or `stop_out` pulse.
- **Single byte:** START, byte 0xA5, 9th clock, STOP. Required response:
  - `start_out` pulses once.
  - `rvalid_out` pulses once with `rdata_out`=0xA5.
  - `ack_slot_out` is high for exactly the 9th SCL low+high period.
  - `stop_out` pulses once; `busy_out` falls with it.
- **Back-to-back:** bytes 0x3C then 0xFF without STOP. Two `rvalid_out` pulses with 0x3C then 0xFF, and two `ack_slot_out` windows.
- **Repeated START after 5 bits:** no `rvalid_out`, a second `start_out` pulse, then the next full byte 0x81 is received correctly.
- **STOP after 3 bits:** `stop_out` pulses and state returns to IDLE. `rdata_out` keeps its previous value and `rvalid_out` stays 0.
- **Glitch/simultaneous:** toggle SDA in the same sample as SCL rising, and vary `SYNC_STAGES`=3. No spurious START/STOP occurs, and event latency is 5 clocks.
